// File: rtl/cen_pkg.sv
// Shared types and constants for the clock-enable generator: FSM state encoding,
// accumulator/counter widths and the default fractional ratios.
package cen_pkg;

  localparam int unsigned CEN_ACC_W = 16;
  localparam int unsigned CEN_CNT_W = 16;

  localparam int unsigned CEN_LOCK_WAIT_DEF = 1024;
  localparam int unsigned CEN_CE0_NUM_DEF   = 16;
  localparam int unsigned CEN_CE0_DEN_DEF   = 250;
  localparam int unsigned CEN_CE1_NUM_DEF   = 1;
  localparam int unsigned CEN_CE1_DEN_DEF   = 4;

  typedef enum logic [1:0] {
    StHold = 2'd0,
    StWait = 2'd1,
    StRun  = 2'd2
  } cen_state_e;

endpackage

// File: rtl/frac_cen.sv
// Fractional clock-enable accumulator: emits Num registered pulses per Den steps,
// spread as evenly as integer arithmetic allows.
module frac_cen
  import cen_pkg::*;
#(
  parameter int unsigned Num = CEN_CE0_NUM_DEF,
  parameter int unsigned Den = CEN_CE0_DEN_DEF
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic step_i,
  input  logic clear_i,
  output logic fire_o,
  output logic pulse_o
);

  localparam logic [CEN_ACC_W-1:0] NumW = CEN_ACC_W'(Num);
  localparam logic [CEN_ACC_W-1:0] DenW = CEN_ACC_W'(Den);

  logic [CEN_ACC_W-1:0] acc_q, acc_d, sum;
  logic                 pulse_q, pulse_d;

  // Den < 32768 and acc < Den keep the sum inside the accumulator width.
  always_comb begin
    sum     = acc_q + NumW;
    fire_o  = step_i && !clear_i && (sum >= DenW);
    acc_d   = acc_q;
    pulse_d = 1'b0;
    if (clear_i) begin
      acc_d = '0;
    end else if (step_i) begin
      acc_d   = fire_o ? (sum - DenW) : sum;
      pulse_d = fire_o;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      acc_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/clock_enable_gen.sv
// Lock-qualified core reset and fractional CPU/sound clock enables.
// Optional macro CEN_PAUSE_EN adds a pause input that freezes the enables.
module clock_enable_gen
  import cen_pkg::*;
#(
  parameter int unsigned LOCK_WAIT = CEN_LOCK_WAIT_DEF,
  parameter int unsigned CE0_NUM   = CEN_CE0_NUM_DEF,
  parameter int unsigned CE0_DEN   = CEN_CE0_DEN_DEF,
  parameter int unsigned CE1_NUM   = CEN_CE1_NUM_DEF,
  parameter int unsigned CE1_DEN   = CEN_CE1_DEN_DEF
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic locked,
  input  logic pause,
  output logic reset_core,
  output logic ce_0,
  output logic ce_1,
  output logic running
);

  if ((CE0_NUM > CE0_DEN) || (CE0_DEN >= 32768) || (CE1_NUM > CE1_DEN) ||
      (CE1_DEN >= 32768) || (LOCK_WAIT < 2) || (LOCK_WAIT > 65535)) begin : g_bad_params
    $error("clock_enable_gen: illegal ratio or LOCK_WAIT parameter");
  end

  localparam logic [CEN_CNT_W-1:0] LockLast = CEN_CNT_W'(LOCK_WAIT - 1);

  logic                 sync1_q, sync2_q, lk_s;
  cen_state_e           state_q, state_d;
  logic [CEN_CNT_W-1:0] cnt_q, cnt_d;
  logic                 reset_core_q, reset_core_d;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= locked;
      sync2_q <= sync1_q;
    end
  end

  assign lk_s = sync2_q;

  // Loss of lock overrides every other transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!lk_s) begin
      state_d = StHold;
    end else begin
      case (state_q)
        StHold: begin
          state_d = StWait;
          cnt_d   = '0;
        end
        StWait: begin
          if (cnt_q == LockLast) state_d = StRun;
          cnt_d = cnt_q + 1'b1;
        end
        StRun:   state_d = StRun;
        default: state_d = StHold;
      endcase
    end
    reset_core_d = (state_d != StRun);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StHold;
      cnt_q        <= '0;
      reset_core_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      reset_core_q <= reset_core_d;
    end
  end

  assign reset_core = reset_core_q;
  assign running    = (state_q == StRun);

  logic in_run, run_step, acc_clear;
  logic ce0_fire, ce0_pulse, ce1_pulse, unused_ce1_fire;

  // Stepping only while staying in RUN suppresses a pulse due on the lock-loss cycle.
  assign in_run    = (state_q == StRun) && (state_d == StRun);
  assign acc_clear = (state_d != StRun);

`ifdef CEN_PAUSE_EN
  assign run_step = in_run && !pause;
  assign ce_0     = ce0_pulse && !pause;
  assign ce_1     = ce1_pulse && !pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign run_step     = in_run;
  assign ce_0         = ce0_pulse;
  assign ce_1         = ce1_pulse;
`endif

  frac_cen #(
    .Num(CE0_NUM),
    .Den(CE0_DEN)
  ) u_ce0 (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .step_i (run_step),
    .clear_i(acc_clear),
    .fire_o (ce0_fire),
    .pulse_o(ce0_pulse)
  );

  frac_cen #(
    .Num(CE1_NUM),
    .Den(CE1_DEN)
  ) u_ce1 (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .step_i (ce0_fire),
    .clear_i(acc_clear),
    .fire_o (unused_ce1_fire),
    .pulse_o(ce1_pulse)
  );

endmodule

// File: doc/clock_enable_gen.md
CLOCK_ENABLE_GEN -- requirements
Module: clock_enable_gen

Interface
REQ-001 Parameter LOCK_WAIT, default 1024: clk_sys cycles that synchronized locked must stay high before core reset releases; range 2..65535.
REQ-002 Parameter CE0_NUM, default 16, and CE0_DEN, default 250: fractional ratio for ce_0 (48 MHz * 16/250 = 3.072 MHz CPU enable).
REQ-003 Parameter CE1_NUM, default 1, and CE1_DEN, default 4: fractional ratio for ce_1, applied to ce_0 pulses (sound/E-clock enable).
REQ-004 clk_sys  input  1  48 MHz PLL output clock; all logic on its rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 locked  input  1  PLL lock flag, asynchronous to clk_sys.
REQ-007 pause  input  1  freezes ce_0/ce_1 generation (only with CEN_PAUSE_EN).
REQ-008 reset_core  output  1  active-high core reset, synchronous to clk_sys.
REQ-009 ce_0  output  1  single-cycle enable pulse.
REQ-010 ce_1  output  1  single-cycle enable pulse, always coincident with a ce_0 pulse.
REQ-011 running  output  1  high while the state machine is in RUN.

Function
REQ-012 locked SHALL pass through a 2-flop synchronizer; lk_s denotes its output.
REQ-013 FSM states SHALL be HOLD, WAIT, RUN.
REQ-014 HOLD -> WAIT when lk_s=1; a 16-bit counter clears on entry to WAIT.
REQ-015 WAIT: counter increments each cycle; WAIT -> RUN on the cycle the counter equals LOCK_WAIT-1.
REQ-016 Any state -> HOLD on the cycle lk_s=0; this has priority over every other transition.
REQ-017 reset_core SHALL be 1 in HOLD and WAIT and 0 in RUN, registered, so it drops on the first RUN cycle.
REQ-018 ce_0 accumulator (16 bits): each RUN cycle, acc0+CE0_NUM is formed; if >= CE0_DEN, acc0 takes sum-CE0_DEN and ce_0=1 on the next cycle, otherwise acc0 takes the sum and ce_0=0.
REQ-019 ce_1 accumulator SHALL use the same rule with CE1_NUM/CE1_DEN, advancing only on cycles where the ce_0 condition fires.
REQ-020 Over any CE0_DEN consecutive RUN cycles, exactly CE0_NUM ce_0 pulses SHALL occur, with no two pulses adjacent when CE0_NUM*2 <= CE0_DEN.
REQ-021 Outside RUN, acc0 and acc1 SHALL clear, and ce_0, ce_1 and running SHALL be 0.
REQ-022 The first ce_0 pulse after entering RUN SHALL occur ceil(CE0_DEN/CE0_NUM) cycles after reset_core falls.
REQ-023 Lock lost mid-RUN: on the cycle lk_s falls, reset_core SHALL go to 1 and any pending ce_0 pulse SHALL be suppressed.
REQ-024 Lock glitch in WAIT SHALL restart the full LOCK_WAIT count.
REQ-025 Parameters SHALL satisfy NUM <= DEN and DEN < 32768, checked by elaboration-time assertion.

Reset
REQ-026 reset_n=0 SHALL asynchronously force the following: synchronizer flops 0, state HOLD, counter 0, acc0/acc1 0, reset_core 1, ce_0/ce_1/running 0.
REQ-027 Reset release SHALL take effect on the first clk_sys edge after reset_n rises; no output toggles during reset.

Configuration
REQ-028 With CEN_PAUSE_EN defined, pause=1 in RUN SHALL hold acc0/acc1 and force ce_0/ce_1 to 0, while reset_core and running stay unchanged; pause=0 resumes from the held accumulator values.
REQ-029 Without CEN_PAUSE_EN, the pause port SHALL exist but be ignored, with no pause logic generated.

Structure
REQ-030 A shared package cen_pkg SHALL hold the FSM state enum (HOLD, WAIT, RUN), accumulator width constant CEN_ACC_W=16, and default ratio constants.
REQ-031 The fractional accumulator SHALL be a sub-module frac_cen (inputs: step enable, clear; output: pulse), instantiated twice.

Verification
REQ-032 reset_n low, locked=1, then release -> reset_core=1 for exactly 2+LOCK_WAIT cycles (1026 at default), then 0, and running=1.
REQ-033 RUN, defaults, 2500 cycles -> exactly 160 ce_0 pulses and 40 ce_1 pulses, each ce_1 coincident with a ce_0.
REQ-034 locked pulsed low for 1 cycle at WAIT count 500 -> return to HOLD, then a full 1024-cycle wait restarts.
REQ-035 locked dropped during RUN on a cycle a ce_0 is due -> no ce_0 pulse, reset_core=1 within 3 cycles of the drop, acc0=0.
REQ-036 CEN_PAUSE_EN, pause=1 for 100 cycles in RUN -> zero ce pulses, reset_core stays 0; after release, the pulse count over 250 cycles is 16.
REQ-037 Assert reset_n low mid-RUN -> all outputs reach reset values with no clock edge.
